// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared types and helpers for the FIFO-draining UART transmitter.
//            Holds the transmitter state encoding, the parity-mode constants
//            and a helper that derives CLKS_PER_BIT from clock and baud rates.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Transmitter states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } state_t;

  // Parity modes, selected by the PARITY_ODD parameter.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Clocks per serial bit, rounded to the nearest integer.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + (baud / 2)) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx_if
// Purpose  : Read-side handshake between a registered-read FIFO and its
//            single reader.
// Signals  : fifo_empty - FIFO empty flag            (FIFO -> reader)
//            fifo_data  - FIFO data_out, valid the cycle after fifo_r_en
//                                                     (FIFO -> reader)
//            fifo_r_en  - one-cycle read strobe       (reader -> FIFO)
// Modports : master - the reader (drives fifo_r_en)
//            slave  - the FIFO   (drives fifo_empty / fifo_data)
// Revision : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_r_en;

  modport master (input fifo_empty, input fifo_data, output fifo_r_en);
  modport slave  (output fifo_empty, output fifo_data, input fifo_r_en);
endinterface
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Purpose  : Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and
//            wraps to 0; bit_tick_o marks the last cycle of each bit period.
// Ports    : clk        - system clock
//            rstn       - synchronous active-low reset
//            clear_i    - force the count to 0 (has priority over enable_i)
//            enable_i   - advance the count
//            bit_tick_o - high in the last cycle of a bit period
//            count_o    - current count
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt #(
  parameter  int CLKS_PER_BIT = 434,
  localparam int CW           = $clog2(CLKS_PER_BIT)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clear_i,
  input  logic          enable_i,
  output logic          bit_tick_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign bit_tick_o = enable_i && (count_q == LAST);
  assign count_o    = count_q;

endmodule
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains a registered-read FIFO one entry at a time and sends each
//            entry as a UART frame: start bit, data LSB first, optional
//            parity bit, STOP_BITS stop bits. All outputs are flops.
// Ports    : clk     - system clock (rising edge)
//            rstn    - synchronous active-low reset
//            fifo    - FIFO read handshake (master side)
//            tx      - serial line, idle high
//            busy    - high whenever the transmitter is not idle
//            tx_done - one-cycle pulse in the last cycle of the final stop bit
// Revision : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  fifo_uart_tx_if.master        fifo,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [CW-1:0] PRE_LAST  = CW'(CLKS_PER_BIT - 2);
  localparam logic          PAR_SEL   = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  r_en_q, r_en_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  baud_en;
  logic                  bit_tick;
  logic [CW-1:0]         baud_count;

  // The bit-period counter only runs inside a frame, so START always begins
  // at count 0.
  assign baud_en = (state_q == START) || (state_q == DATA) ||
                   (state_q == PARITY) || (state_q == STOP);

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk        (clk),
    .rstn       (rstn),
    .clear_i    (!baud_en),
    .enable_i   (baud_en),
    .bit_tick_o (bit_tick),
    .count_o    (baud_count)
  );

  // tx_d is the line level for the next cycle, so it is set on each
  // transition to match the state being entered.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bit_d    = bit_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    r_en_d   = 1'b0;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!fifo.fifo_empty) begin
          state_d = REQ;
          r_en_d  = 1'b1;
        end
      end
      REQ: begin
        state_d = LOAD;
      end
      LOAD: begin
        shift_d  = fifo.fifo_data;
        parity_d = (^fifo.fifo_data) ^ PAR_SEL;
        bit_d    = '0;
        state_d  = START;
        tx_d     = 1'b0;
      end
      START: begin
        if (bit_tick) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_q == LAST_DATA) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end
      end
      PARITY: begin
        if (bit_tick) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
      STOP: begin
        // Registered pulse: raise it one cycle early so it lands in the
        // final cycle of the last stop bit.
        if ((bit_q == LAST_STOP) && (baud_count == PRE_LAST)) begin
          done_d = 1'b1;
        end
        if (bit_tick) begin
          if (bit_q == LAST_STOP) begin
            bit_d   = '0;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bit_q    <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
      r_en_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      bit_q    <= bit_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
      r_en_q   <= r_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign fifo.fifo_r_en = r_en_q;
  assign tx             = tx_q;
  assign busy           = busy_q;
  assign tx_done        = done_q;

endmodule
`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Downstream drain stage for sync_fifo. Whenever the FIFO is non-empty it pops one byte and sends it as an asynchronous UART frame on a single serial line. Frame format: start bit, data bits LSB first, optional parity bit, stop bit(s). It connects directly to the FIFO's data_out/empty/r_en ports and is the only reader of that FIFO.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); must be >= 2.
DATA_WIDTH, 8, bits per frame; must match the FIFO data width.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits, 1 or 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rstn  input  1  reset, synchronous, active-low.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after fifo_r_en is high (registered FIFO read).
fifo_r_en  output  1  FIFO read strobe; registered; high for exactly one cycle per frame.
tx  output  1  serial line; registered; idle high.
busy  output  1  high whenever state != IDLE.
tx_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (rstn=0 at a rising edge): next cycle tx=1, fifo_r_en=0, busy=0, tx_done=0, state=IDLE, counters=0, shift register=0. fifo_empty is ignored while in reset.
- States: IDLE, REQ, LOAD, START, DATA, PARITY, STOP.
- IDLE: tx=1. If fifo_empty=0 at the edge, go to REQ.
- REQ: fifo_r_en=1 for exactly this cycle, then go to LOAD.
- LOAD: capture fifo_data into the shift register and compute parity (XOR of data, inverted if PARITY_ODD), then go to START.
- START: tx=0 for CLKS_PER_BIT cycles.
- DATA: tx = shift[0]; shift right every CLKS_PER_BIT cycles; DATA_WIDTH bits, LSB first.
- PARITY: entered only if PARITY_EN=1; tx = parity bit for CLKS_PER_BIT cycles.
- STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles. tx_done=1 in the final cycle, then go to IDLE.
- Latency:
  - If IDLE samples fifo_empty=0 at edge k, fifo_r_en is high in cycle k+1 and tx falls in cycle k+3.
  - Back-to-back frames have exactly 3 idle-high cycles between the end of stop and the next start bit (IDLE, REQ, LOAD).
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) * CLKS_PER_BIT cycles.
- fifo_r_en is never asserted from IDLE when fifo_empty=1, and at most once per frame. No pop occurs mid-frame.
- Once START is entered, fifo_empty changes do not affect the frame in progress.
- Baud counter width: $clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0, and advances the bit when the count reaches CLKS_PER_BIT-1. Bit counter width: $clog2(DATA_WIDTH+1).
- Reset mid-frame: frame abandoned and the byte lost; tx=1 the cycle after the reset edge. After release, the block restarts from IDLE with the next FIFO entry.
- No glitches on tx: all outputs are flops.

Decomposition:
- Package uart_pkg:
  - state enum (IDLE..STOP);
  - parity-mode constants;
  - function clks_per_bit(clk_hz, baud).
- One natural sub-module, uart_baud_cnt:
  - inputs: clear, enable;
  - outputs: bit_tick pulse and count;
  - parameterised by CLKS_PER_BIT.
- The FSM and shift register stay in fifo_uart_tx.

Test Plan:
1. Reset: hold rstn=0 for 5 cycles with fifo_empty=0 -> tx=1, busy=0, fifo_r_en=0, no pop. After release, fifo_r_en pulses in the 2nd cycle.
2. Single byte, CLKS_PER_BIT=4, fifo_data=0xA5 -> tx falls 3 cycles after empty deasserts. tx = 0, then 1,0,1,0,0,1,0,1, then 1, each held 4 cycles (40 cycles total). tx_done pulses at cycle 40 of the frame. Exactly one fifo_r_en.
3. Back-to-back: FIFO preloaded with 0x00, 0xFF, 0x55 -> three frames with exactly 3 idle-high cycles between them. Total fifo_r_en count = 3. No strobe after fifo_empty rises. busy drops 1 cycle after the last tx_done.
4. Parity: PARITY_EN=1, PARITY_ODD=0, byte 0x07 -> parity bit 1, 11-bit frame (44 cycles). Repeat with PARITY_ODD=1 -> parity bit 0.
5. Reset mid-DATA: rstn=0 for one cycle during bit 3 of 0x3C -> next cycle tx=1 and busy=0. After release, the next FIFO byte is sent in full; 0x3C is not retransmitted.
6. Integration with sync_fifo: write 0x01..0x08 while draining, CLKS_PER_BIT=4 -> UART decoder receives 0x01..0x08 in order. No byte lost or duplicated. fifo_r_en is never high while empty=1.
